// File: rtl/aes_bus_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : aes_bus_bridge
//  Purpose  : Byte-serial host bridge. Decodes framed command bytes into
//             single-cycle accesses on the AES core register bus and streams
//             read data or a status byte back out.
//  Revision : 1.0 - initial release
// ============================================================================
module aes_bus_bridge #(
    parameter int unsigned TIMEOUT  = 255,
    parameter logic [7:0]  RESP_ACK = 8'h5A,
    parameter logic [7:0]  RESP_ERR = 8'hEE
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        cs,
    output logic        we,
    output logic [7:0]  address,
    output logic [31:0] write_data,
    input  logic [31:0] read_data,
    output logic        busy
);

    localparam logic [7:0]  c_OP_READ  = 8'h01;
    localparam logic [7:0]  c_OP_WRITE = 8'h02;
    localparam int unsigned c_TMO_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [c_TMO_W-1:0] c_TMO_LAST = (TIMEOUT > 0) ? c_TMO_W'(TIMEOUT - 1) : '0;
    localparam logic [c_TMO_W-1:0] c_TMO_ONE  = c_TMO_W'(1);

    typedef enum logic [2:0] {
        S_CMD   = 3'd0,
        S_ADDR  = 3'd1,
        S_WDATA = 3'd2,
        S_BUS   = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    // Kind of frame being processed; K_ERR marks an illegal opcode.
    typedef enum logic [1:0] {
        K_READ  = 2'd0,
        K_WRITE = 2'd1,
        K_ERR   = 2'd2
    } kind_t;

    state_t               r_state;
    state_t               w_state_nxt;
    kind_t                r_kind;
    logic [1:0]           r_byte_cnt;
    logic [c_TMO_W-1:0]   r_tmo_cnt;
    logic [31:0]          r_rdata;

    logic                 w_in_xfer;
    logic                 w_out_xfer;
    logic                 w_tmo_hit;
    logic                 w_resp_last;
    logic [1:0]           w_cnt_inc;
    logic [7:0]           w_resp_byte;
    logic [7:0]           w_resp_byte_nxt;

    assign w_in_xfer   = in_valid & in_ready;
    assign w_out_xfer  = out_valid & out_ready;
    // Abort fires on the idle cycle that would bring the count up to TIMEOUT.
    assign w_tmo_hit   = (TIMEOUT != 0) && (r_tmo_cnt == c_TMO_LAST);
    assign w_resp_last = (r_kind != K_READ) || (r_byte_cnt == 2'd3);
    assign w_cnt_inc   = r_byte_cnt + 2'd1;

    // Response byte at the current index and at the following index.
    always_comb begin
        w_resp_byte     = RESP_ACK;
        w_resp_byte_nxt = RESP_ACK;
        if (r_kind == K_READ) begin
            case (r_byte_cnt)
                2'd0:    w_resp_byte = r_rdata[31:24];
                2'd1:    w_resp_byte = r_rdata[23:16];
                2'd2:    w_resp_byte = r_rdata[15:8];
                default: w_resp_byte = r_rdata[7:0];
            endcase
            case (w_cnt_inc)
                2'd0:    w_resp_byte_nxt = r_rdata[31:24];
                2'd1:    w_resp_byte_nxt = r_rdata[23:16];
                2'd2:    w_resp_byte_nxt = r_rdata[15:8];
                default: w_resp_byte_nxt = r_rdata[7:0];
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_CMD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode plus the state-decoded handshake and busy outputs.
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        busy        = 1'b1;
        case (r_state)
            S_CMD: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (w_in_xfer) begin
                    if ((in_data == c_OP_READ) || (in_data == c_OP_WRITE)) begin
                        w_state_nxt = S_ADDR;
                    end else begin
                        w_state_nxt = S_RESP;
                    end
                end
            end
            S_ADDR: begin
                in_ready = 1'b1;
                if (w_in_xfer) begin
                    w_state_nxt = (r_kind == K_WRITE) ? S_WDATA : S_BUS;
                end else if (w_tmo_hit) begin
                    w_state_nxt = S_CMD;
                end
            end
            S_WDATA: begin
                in_ready = 1'b1;
                if (w_in_xfer) begin
                    if (r_byte_cnt == 2'd3) begin
                        w_state_nxt = S_BUS;
                    end
                end else if (w_tmo_hit) begin
                    w_state_nxt = S_CMD;
                end
            end
            S_BUS: begin
                w_state_nxt = S_RESP;
            end
            S_RESP: begin
                if (w_out_xfer && w_resp_last) begin
                    w_state_nxt = S_CMD;
                end
            end
            default: begin
                w_state_nxt = S_CMD;
            end
        endcase
    end

    // Datapath: frame capture, bus strobe, read capture and response stream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs         <= 1'b0;
            we         <= 1'b0;
            address    <= 8'h00;
            write_data <= 32'h0;
            out_valid  <= 1'b0;
            out_data   <= 8'h00;
            r_kind     <= K_READ;
            r_byte_cnt <= 2'd0;
            r_tmo_cnt  <= '0;
            r_rdata    <= 32'h0;
        end else begin
            // cs is high exactly for the single cycle spent in BUS.
            cs <= (w_state_nxt == S_BUS);
            we <= (w_state_nxt == S_BUS) && (r_kind == K_WRITE);
            case (r_state)
                S_CMD: begin
                    r_tmo_cnt <= '0;
                    if (w_in_xfer) begin
                        if (in_data == c_OP_READ) begin
                            r_kind <= K_READ;
                        end else if (in_data == c_OP_WRITE) begin
                            r_kind <= K_WRITE;
                        end else begin
                            r_kind    <= K_ERR;
                            out_data  <= RESP_ERR;
                            out_valid <= 1'b1;
                        end
                    end
                end
                S_ADDR: begin
                    if (w_in_xfer) begin
                        address    <= in_data;
                        r_byte_cnt <= 2'd0;
                        r_tmo_cnt  <= '0;
                    end else if (w_tmo_hit) begin
                        r_tmo_cnt <= '0;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + c_TMO_ONE;
                    end
                end
                S_WDATA: begin
                    if (w_in_xfer) begin
                        write_data <= {write_data[23:0], in_data};
                        r_byte_cnt <= w_cnt_inc;
                        r_tmo_cnt  <= '0;
                    end else if (w_tmo_hit) begin
                        r_tmo_cnt <= '0;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + c_TMO_ONE;
                    end
                end
                S_BUS: begin
                    if (r_kind == K_READ) begin
                        r_rdata <= read_data;
                    end
                    r_byte_cnt <= 2'd0;
                end
                S_RESP: begin
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                        out_data  <= w_resp_byte;
                    end else if (out_ready) begin
                        if (w_resp_last) begin
                            out_valid <= 1'b0;
                        end else begin
                            r_byte_cnt <= w_cnt_inc;
                            out_data   <= w_resp_byte_nxt;
                        end
                    end
                end
                default: begin
                    r_tmo_cnt <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
